sequential_squarer: RTL
=======================

// Module: sequential_squarer
// PURPOSE
//  Iterative shift-add squarer: computes operand_i**2 over IN_W cycles.
//  Inverse companion of the square-root datapath. Squares a root candidate
//  so the result can be checked against the radicand by the 17-bit Comparator.
//  Sits beside the square-root core. Driven by a start/done handshake from the
//  controlling FSM or testbench.
// PARAMETERS
//  IN_W      8            operand width in bits (>=2)
//  RES_W     2*IN_W+1     result width; 17 at default, matches the Comparator inputs
// PORTS
//  clk_i      in   1      single clock, rising edge
//  rst_n_i    in   1      asynchronous active-low reset
//  start_i    in   1      request; sampled only in IDLE
//  operand_i  in   IN_W   unsigned value to square; sampled with start_i
//  busy_o     out  1      high in CALC and DONE
//  done_o     out  1      one-cycle pulse: square_o newly valid
//  square_o   out  RES_W  unsigned result, zero-extended; held until next result
// BEHAVIOUR
//  Reset (async, rst_n_i=0): state=IDLE, busy_o=0, done_o=0, square_o=0.
//    Internal accumulator, multiplier and counter registers are also cleared.
//    Takes effect immediately, from any state.
//  FSM states: IDLE, CALC, DONE.
//  IDLE: start_i=1 at an edge -> CALC.
//    Same edge: mcand<=operand_i, mplier<=operand_i, acc<=0, cnt<=0.
//    start_i=0 -> stay in IDLE.
//  CALC, each edge:
//    if mplier[0]: acc <= acc + (mcand << cnt), computed at RES_W width;
//    mplier <= mplier>>1; cnt <= cnt+1.
//    On the edge where cnt==IN_W-1: square_o <= final acc (including this
//    edge's add), then -> DONE.
//  DONE: done_o=1 for exactly this one cycle. Next edge -> IDLE unconditionally.
//  Latency: start accepted at edge k. CALC occupies edges k+1..k+IN_W.
//    done_o is high in the cycle following edge k+IN_W. Back-to-back throughput
//    is one result per IN_W+2 cycles.
//  start_i is ignored while busy_o=1, including the DONE cycle. No queuing.
//    operand_i changes during CALC have no effect.
//  square_o changes only on the DONE-entry edge or at reset.
//    It keeps its previous value during CALC.
//  Arithmetic: all unsigned. Max result (2^IN_W-1)^2 < 2^(2*IN_W), so the MSB
//    of square_o is always 0 and no overflow is possible.
//  cnt width: $clog2(IN_W). No wrap occurs because CALC exits at IN_W-1.
//  Reset mid-CALC: discard the computation. square_o=0, no done_o pulse.
//  done_o and busy_o are registered state decodes: no combinational path
//    from any input to any output.
// STRUCTURE
//  Package sqrt_pkg:
//    typedef enum logic [1:0] {IDLE, CALC, DONE} sq_state_t;
//    localparam DATA_W = 17, matching the Comparator width.
//  Sub-module squarer_datapath holds the acc/mcand/mplier/cnt registers and
//    the adder. The top level keeps the FSM only; the datapath is controlled
//    by load/step enables and returns a last_step flag.
// TESTING
//  1. Reset held, then released: busy_o=0, done_o=0, square_o=0.
//  2. operand_i=8'd0, start pulse -> done_o high 8 edges after acceptance,
//     square_o=17'd0.
//  3. operand_i=8'd255 -> square_o=17'd65025 (17'h0FE01), bit 16 = 0.
//  4. operand_i=8'd181 -> square_o=17'd32761. Feed square_o and
//     radicand 17'd32768 to the Comparator: A_less_than_B_o=1.
//  5. start_i held high continuously with operand_i=8'd3:
//     - results 9, 9 appear with done_o pulses exactly 10 cycles apart;
//     - changing operand_i to 8'd7 during CALC does not affect the
//       current result (9).
//  6. rst_n_i=0 asserted mid-CALC (operand_i=8'd100, after 3 steps):
//     - outputs clear immediately and no done_o follows;
//     - a fresh start with 8'd100 then yields 17'd10000.

Source files
------------

// File: rtl/sqrt_pkg.sv
// Shared types and constants for the square-root datapath family.
// The squarer FSM state encoding lives here so controllers and benches agree on it.
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } sq_state_t;

  localparam int DATA_W = 17;

endpackage

// File: rtl/squarer_datapath.sv
// Shift-add datapath for the iterative squarer: operand copies, accumulator,
// step counter and the held result register.
module squarer_datapath
  import sqrt_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int RES_W = 2 * IN_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [IN_W-1:0]  operand,
  output logic             last_step,
  output logic [RES_W-1:0] square
);

  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;

  logic [IN_W-1:0]  mcand;
  logic [IN_W-1:0]  mplier;
  logic [RES_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [RES_W-1:0] partial;
  logic [RES_W-1:0] acc_next;

  // Partial product is the multiplicand shifted by the current bit position.
  always_comb begin
    partial   = mplier[0] ? (RES_W'(mcand) << cnt) : '0;
    acc_next  = acc + partial;
    last_step = (cnt == CNT_W'(IN_W - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      square <= '0;
    end else if (load) begin
      mcand  <= operand;
      mplier <= operand;
      acc    <= '0;
      cnt    <= '0;
    end else if (step) begin
      acc    <= acc_next;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (last_step) begin
        square <= acc_next;
      end
    end
  end

endmodule

// File: rtl/sequential_squarer.sv
// Iterative squarer: start/done handshake around a shift-add datapath,
// one result every IN_W+2 cycles; outputs are pure decodes of registered state.
module sequential_squarer
  import sqrt_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int RES_W = 2 * IN_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [IN_W-1:0]  operand_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [RES_W-1:0] square_o
);

  sq_state_t state;
  sq_state_t state_next;
  logic      load;
  logic      step;
  logic      last_step;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // start_i only matters in IDLE, so requests during CALC/DONE are dropped.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          load       = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy_o = (state != IDLE);
  assign done_o = (state == DONE);

  squarer_datapath #(
    .IN_W  (IN_W),
    .RES_W (RES_W)
  ) u_datapath (
    .clk       (clk_i),
    .rst_n     (rst_n_i),
    .load      (load),
    .step      (step),
    .operand   (operand_i),
    .last_step (last_step),
    .square    (square_o)
  );

endmodule
